// File: rtl/ez8_io_pkg.sv
// Shared register map, field positions and small helpers for the ez8 IO window.
package ez8_io_pkg;

    localparam int IO_WIN = 8;

    localparam logic [2:0] OFF_GPIO_OUT = 3'd0;
    localparam logic [2:0] OFF_GPIO_IN  = 3'd1;
    localparam logic [2:0] OFF_TMR_CNT  = 3'd2;
    localparam logic [2:0] OFF_TMR_PER  = 3'd3;
    localparam logic [2:0] OFF_TMR_CTRL = 3'd4;
    localparam logic [2:0] OFF_IFLAG    = 3'd5;
    localparam logic [2:0] OFF_IMASK    = 3'd6;
    localparam logic [2:0] OFF_PWM_CMP  = 3'd7;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_PS_LSB = 1;
    localparam int CTRL_PS_MSB = 3;

    localparam int IF_TMR = 0;
    localparam int IF_PIN = 1;

    // Prescaler terminal count for a given prescale select: 2^ps - 1.
    function automatic logic [7:0] ps_limit(input logic [2:0] ps);
        ps_limit = (8'd1 << ps) - 8'd1;
    endfunction

    // True for offsets that are software-writable and therefore eligible for read bypass.
    function automatic logic off_is_rw(input logic [2:0] off, input logic pwm_en);
        case (off)
            OFF_GPIO_OUT, OFF_TMR_CNT, OFF_TMR_PER,
            OFF_TMR_CTRL, OFF_IMASK:  off_is_rw = 1'b1;
            OFF_PWM_CMP:              off_is_rw = pwm_en;
            default:                  off_is_rw = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/io_timer.sv
// Prescaled 8-bit timer with period compare and overflow pulse.
// Optional PWM compare output when IO_PWM_EN is defined.
module io_timer
    import ez8_io_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       en_i,
    input  logic [2:0] ps_i,
    input  logic [7:0] per_i,
    input  logic       cnt_we_i,
    input  logic [7:0] cnt_wdata_i,
`ifdef IO_PWM_EN
    input  logic [7:0] cmp_i,
    output logic       pwm_o,
`endif
    output logic [7:0] cnt_o,
    output logic       ovf_o
);

    logic [7:0] presc_q;
    logic [7:0] presc_d;
    logic [7:0] cnt_q;
    logic [7:0] cnt_d;
    logic       tick_s;
    logic       wrap_s;

    // Prescaler/counter next state; a software count write beats the tick and its overflow.
    always_comb begin
        tick_s  = en_i && (presc_q == ps_limit(ps_i));
        presc_d = (!en_i || tick_s) ? 8'd0 : presc_q + 8'd1;
        wrap_s  = tick_s && (cnt_q == per_i);
        if (cnt_we_i) begin
            cnt_d = cnt_wdata_i;
        end else if (tick_s) begin
            cnt_d = wrap_s ? 8'd0 : cnt_q + 8'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    assign ovf_o = wrap_s && !cnt_we_i;
    assign cnt_o = cnt_q;

    // Prescaler and count registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            presc_q <= 8'd0;
            cnt_q   <= 8'd0;
        end else begin
            presc_q <= presc_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef IO_PWM_EN
    logic pwm_q;

    // PWM level is high while the count sits below the compare value.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pwm_q <= 1'b0;
        end else begin
            pwm_q <= en_i && (cnt_q < cmp_i);
        end
    end

    assign pwm_o = pwm_q;
`endif

endmodule

// File: rtl/io_ctrl.sv
// ez8 IO window responder: GPIO, prescaled timer, interrupt flags/mask.
// Optional PWM compare register and pwm_out port under IO_PWM_EN.
module io_ctrl
    import ez8_io_pkg::*;
#(
    parameter logic [7:0] IO_BASE     = 8'h08,
    parameter int         SYNC_STAGES = 2
)(
    input  logic       clk,
    input  logic       reset,
    input  logic       pause,
    input  logic [7:0] writeaddr,
    input  logic [7:0] writedata,
    input  logic       write_en,
    input  logic [7:0] readaddr,
    output logic [7:0] readdata,
    input  logic [7:0] gpio_in,
    output logic [7:0] gpio_out,
    output logic       irq
`ifdef IO_PWM_EN
    ,
    output logic       pwm_out
`endif
);

`ifdef IO_PWM_EN
    localparam logic PWM_EN_C = 1'b1;
`else
    localparam logic PWM_EN_C = 1'b0;
`endif

    logic [7:0] gpio_out_q, gpio_out_d;
    logic [7:0] per_q, per_d;
    logic [3:0] ctrl_q, ctrl_d;
    logic [1:0] iflag_q, iflag_d;
    logic [1:0] imask_q, imask_d;
    logic [7:0] readdata_q, readdata_d;
    logic [SYNC_STAGES-1:0][7:0] sync_q;
    logic       pin_prev_q;

    logic       wr_hit_s, rd_hit_s, bypass_s;
    logic [2:0] wr_off_s;
    logic [7:0] we_s;
    logic [7:0] rd_val_s;
    logic [7:0] gpio_sync_s;
    logic       pin_chg_s;
    logic [7:0] cnt_s;
    logic       ovf_s;
    logic [1:0] iflag_set_s, iflag_clr_s;
`ifdef IO_PWM_EN
    logic [7:0] cmp_q, cmp_d;
`endif

    assign wr_hit_s    = write_en && (writeaddr[7:3] == IO_BASE[7:3]);
    assign rd_hit_s    = (readaddr[7:3] == IO_BASE[7:3]);
    assign wr_off_s    = writeaddr[2:0];
    assign we_s        = wr_hit_s ? (8'd1 << wr_off_s) : 8'd0;
    assign gpio_sync_s = sync_q[SYNC_STAGES-1];
    assign pin_chg_s   = gpio_sync_s[0] ^ pin_prev_q;

    // Register write decode and flag update; hardware set wins over write-1-to-clear.
    always_comb begin
        gpio_out_d  = we_s[OFF_GPIO_OUT] ? writedata      : gpio_out_q;
        per_d       = we_s[OFF_TMR_PER]  ? writedata      : per_q;
        ctrl_d      = we_s[OFF_TMR_CTRL] ? writedata[3:0] : ctrl_q;
        imask_d     = we_s[OFF_IMASK]    ? writedata[1:0] : imask_q;
        iflag_clr_s = we_s[OFF_IFLAG]    ? writedata[1:0] : 2'b00;
        iflag_set_s = 2'b00;
        iflag_set_s[IF_TMR] = ovf_s;
        iflag_set_s[IF_PIN] = pin_chg_s;
        iflag_d     = (iflag_q & ~iflag_clr_s) | iflag_set_s;
`ifdef IO_PWM_EN
        cmp_d       = we_s[OFF_PWM_CMP]  ? writedata      : cmp_q;
`endif
    end

    // Read mux with same-cycle bypass for writable registers; IFLAG always shows its old value.
    always_comb begin
        rd_val_s = 8'd0;
        case (readaddr[2:0])
            OFF_GPIO_OUT: rd_val_s = gpio_out_q;
            OFF_GPIO_IN:  rd_val_s = gpio_sync_s;
            OFF_TMR_CNT:  rd_val_s = cnt_s;
            OFF_TMR_PER:  rd_val_s = per_q;
            OFF_TMR_CTRL: rd_val_s = {4'd0, ctrl_q};
            OFF_IFLAG:    rd_val_s = {6'd0, iflag_q};
            OFF_IMASK:    rd_val_s = {6'd0, imask_q};
`ifdef IO_PWM_EN
            OFF_PWM_CMP:  rd_val_s = cmp_q;
`endif
            default:      rd_val_s = 8'd0;
        endcase
        bypass_s = wr_hit_s && (writeaddr == readaddr) && off_is_rw(wr_off_s, PWM_EN_C);
        if (!rd_hit_s) begin
            readdata_d = 8'd0;
        end else if (bypass_s) begin
            readdata_d = writedata;
        end else begin
            readdata_d = rd_val_s;
        end
    end

    // Register state, synchroniser chain and paused read sampling.
    always_ff @(posedge clk) begin
        if (!reset) begin
            gpio_out_q <= 8'd0;
            per_q      <= 8'd0;
            ctrl_q     <= 4'd0;
            iflag_q    <= 2'b00;
            imask_q    <= 2'b00;
            readdata_q <= 8'd0;
            sync_q     <= '0;
            pin_prev_q <= 1'b0;
        end else begin
            gpio_out_q <= gpio_out_d;
            per_q      <= per_d;
            ctrl_q     <= ctrl_d;
            iflag_q    <= iflag_d;
            imask_q    <= imask_d;
            sync_q     <= {sync_q[SYNC_STAGES-2:0], gpio_in};
            pin_prev_q <= gpio_sync_s[0];
            if (!pause) begin
                readdata_q <= readdata_d;
            end
        end
    end

`ifdef IO_PWM_EN
    // PWM compare register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cmp_q <= 8'd0;
        end else begin
            cmp_q <= cmp_d;
        end
    end
`endif

    io_timer u_timer (
        .clk         (clk),
        .reset       (reset),
        .en_i        (ctrl_q[CTRL_EN]),
        .ps_i        (ctrl_q[CTRL_PS_MSB:CTRL_PS_LSB]),
        .per_i       (per_q),
        .cnt_we_i    (we_s[OFF_TMR_CNT]),
        .cnt_wdata_i (writedata),
`ifdef IO_PWM_EN
        .cmp_i       (cmp_q),
        .pwm_o       (pwm_out),
`endif
        .cnt_o       (cnt_s),
        .ovf_o       (ovf_s)
    );

    assign readdata = readdata_q;
    assign gpio_out = gpio_out_q;
    assign irq      = |(iflag_q & imask_q);

endmodule
